gcd_arbiter: RTL and testbench
==============================

# gcd_arbiter

Round-robin arbiter and sequencer that shares one subtractive GCD engine among `N` requesters. It accepts one operand pair at a time, launches the engine, waits for completion under a watchdog, and returns the result to the requester that was granted. Zero operands are resolved locally and never reach the engine. The block sits between client logic and the GCD engine; the engine uses the same `clk`/`clr`.

## Interface

Parameters:
- `N`, 4: number of requesters.
- `W`, 4: operand/result width.
- `TIMEOUT`, 64: maximum cycles in WAIT before abort. Must be ≥ 2.

Ports:
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  reset, asynchronous, active-high.
- `req`  in  N  per-requester request level.
- `req_x`  in  N*W  operand x; requester i uses slice [i*W +: W].
- `req_y`  in  N*W  operand y; same slicing as `req_x`.
- `gnt`  out  N  one-hot, one-cycle pulse: request accepted, operands captured.
- `rsp_valid`  out  N  one-hot, one-cycle pulse: result for requester i.
- `rsp_data`  out  W  result; valid only while `rsp_valid` is nonzero.
- `rsp_err`  out  1  qualifies `rsp_valid`: watchdog abort, `rsp_data`=0.
- `busy`  out  1  high in every state except IDLE.
- `eng_go`  out  1  one-cycle engine start.
- `eng_x`, `eng_y`  out  W each  engine operands, held stable from LAUNCH through WAIT.
- `eng_done`  in  1  engine completion pulse.
- `eng_gcd`  in  W  engine result, sampled when `eng_done`=1.

## Operation

- States: IDLE, LAUNCH, WAIT, RESP. All outputs are decoded from registered state. No combinational path from any input to any output.
- IDLE, `req`≠0:
  - Select the first asserted requester searching upward, with wrap, from `ptr+1` mod N.
  - Latch its index, `req_x` slice and `req_y` slice.
  - Go to LAUNCH.
- IDLE, `req`=0: stay.
- LAUNCH (1 cycle):
  - `gnt[idx]`=1.
  - If both latched operands are nonzero: `eng_go`=1, clear the timer, go to WAIT.
  - Otherwise: `eng_go`=0, result = x|y (gcd(0,y)=y, gcd(x,0)=x, gcd(0,0)=0), go to RESP.
- WAIT:
  - `eng_done`=1: capture `eng_gcd`, set err=0, go to RESP.
  - Else, timer = TIMEOUT−1: set result=0, err=1, go to RESP.
  - Else: increment timer.
- RESP (1 cycle):
  - `rsp_valid[idx]`=1, `rsp_data`=result, `rsp_err`=err.
  - Set `ptr`=idx.
  - Go to IDLE.
- `eng_done` is ignored outside WAIT, including a late done arriving after a timeout.
- Requester rules:
  - Hold `req` and operands until `gnt`, then drop `req` or present a new pair.
  - A requester may re-request immediately after `gnt`. It is not re-arbitrated until IDLE.
- Fairness: a requester is served at most once before every other pending requester is served once.

## Timing

- Reset values:
  - `gnt`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, `eng_go`=0, `eng_x`=0, `eng_y`=0.
  - State=IDLE, timer=0.
  - `ptr`=N−1, so requester 0 has first priority.
- `clr` asserted in any state returns everything to reset values asynchronously. The in-flight request is dropped with no response. The engine is reset by the same `clr`.
- Request sampled in IDLE at cycle T:
  - `gnt` and `eng_go` are asserted at T+1.
  - Done sampled at cycle D (D ≥ T+2) gives `rsp_valid` at D+1 and IDLE at D+2.
  - The next `gnt` is at D+3 at the earliest.
- Zero-operand path: `gnt` at T+1, `rsp_valid` at T+2.
- Timeout path: WAIT spans exactly TIMEOUT cycles (T+2 … T+1+TIMEOUT), `rsp_valid` with `rsp_err`=1 at T+2+TIMEOUT.
- `eng_done` in the same cycle the timer reaches TIMEOUT−1: done wins, no error.

## Test plan

- Single request, requester 2, x=12, y=8; model engine returns done 5 cycles after `eng_go` with 4 → `gnt`=0100 at T+1; `eng_go` at T+1 with `eng_x`=12, `eng_y`=8; `rsp_valid`=0100, `rsp_data`=4, `rsp_err`=0 one cycle after done.
- All four requesters assert continuously from reset → grant order 0,1,2,3,0; every `gnt` is one-hot; `busy` drops for exactly one cycle between jobs.
- Requester 1 with x=0, y=9, then requester 3 with x=0, y=0 → `rsp_data`=9, then 0; `eng_go` never asserts; `rsp_valid` two cycles after the request sample.
- Engine never returns done, TIMEOUT=64 → `rsp_valid` with `rsp_err`=1, `rsp_data`=0 exactly 66 cycles after the request sample; a done pulse injected afterwards produces no response; the next request is served normally.
- Done coincides with the final timer cycle, `eng_gcd`=3 → `rsp_data`=3, `rsp_err`=0.
- `clr` pulsed mid-WAIT → all outputs 0 immediately; no `rsp_valid` for the dropped job; requester 0 wins the first arbitration after reset.

Source files
------------

// File: rtl/gcd_arbiter_if.sv
// Request/response and engine-side signal bundle for gcd_arbiter.
// The arbiter takes the slave view; clients and the engine model take the master view.
interface gcd_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
);
  logic [N-1:0]   req;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           busy;
  logic           eng_go;
  logic [W-1:0]   eng_x;
  logic [W-1:0]   eng_y;
  logic           eng_done;
  logic [W-1:0]   eng_gcd;

  modport slave (
    input  req, req_x, req_y, eng_done, eng_gcd,
    output gnt, rsp_valid, rsp_data, rsp_err, busy, eng_go, eng_x, eng_y
  );

  modport master (
    output req, req_x, req_y, eng_done, eng_gcd,
    input  gnt, rsp_valid, rsp_data, rsp_err, busy, eng_go, eng_x, eng_y
  );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one GCD engine among N requesters, with a
// local zero-operand shortcut and a watchdog on the engine wait.
module gcd_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input logic          clk,
  input logic          clr,
  gcd_arbiter_if.slave bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  x_q, x_d, y_q, y_d;
  logic [W-1:0]  res_q, res_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [IW-1:0] pick, cand;
  logic          found;
  logic [W-1:0]  x_sel, y_sel;
  logic          both_nz;

  assign both_nz = (x_q != '0) && (y_q != '0);

  // Search upward from the slot after the last served requester, with wrap.
  always_comb begin
    pick  = ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= int'(N); i++) begin
      cand = IW'((int'(ptr_q) + i) % int'(N));
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    x_sel = '0;
    y_sel = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (pick == IW'(i)) begin
        x_sel = bus.req_x[i*W +: W];
        y_sel = bus.req_y[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    err_d   = err_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          idx_d   = pick;
          x_d     = x_sel;
          y_d     = y_sel;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        timer_d = '0;
        if (both_nz) begin
          state_d = StWait;
        end else begin
          // gcd with a zero operand is the other operand
          res_d   = x_q | y_q;
          err_d   = 1'b0;
          state_d = StResp;
        end
      end
      StWait: begin
        if (bus.eng_done) begin
          res_d   = bus.eng_gcd;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        ptr_d   = idx_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ptr_q   <= IW'(N - 1);
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    bus.gnt       = '0;
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    bus.rsp_err   = 1'b0;
    bus.busy      = (state_q != StIdle);
    bus.eng_go    = (state_q == StLaunch) && both_nz;
    bus.eng_x     = x_q;
    bus.eng_y     = y_q;
    if (state_q == StLaunch) begin
      bus.gnt[idx_q] = 1'b1;
    end
    if (state_q == StResp) begin
      bus.rsp_valid[idx_q] = 1'b1;
      bus.rsp_data         = res_q;
      bus.rsp_err          = err_q;
    end
  end
endmodule

// File: tb/tb_gcd_arbiter.sv
// Randomised and directed bench for gcd_arbiter: a grant monitor predicts the
// round-robin winner and pushes expected responses; a response monitor pops them.
module tb_gcd_arbiter;
  localparam int unsigned N       = 4;
  localparam int unsigned W       = 4;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  gcd_arbiter_if #(.N(N), .W(W)) bus ();

  gcd_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] req_x = '0;
  logic [N*W-1:0] req_y = '0;
  logic           eng_pulse, late_pulse;
  logic [W-1:0]   eng_val;
  bit             eng_hang = 1'b0;
  bit             eng_rand = 1'b0;
  int             lat_cfg  = 5;
  int             rnd_lat;
  int             eng_lat;

  assign bus.req      = req;
  assign bus.req_x    = req_x;
  assign bus.req_y    = req_y;
  assign bus.eng_done = eng_pulse | late_pulse;
  assign bus.eng_gcd  = eng_val;
  assign eng_lat      = eng_rand ? rnd_lat : lat_cfg;

  typedef struct {
    int         idx;
    logic [W-1:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  // Reference model state: last served requester and the pending prediction.
  int           last = N - 1;
  bit           pred_valid = 1'b0;
  int           pred_idx;
  logic [W-1:0] px, py;
  int           idle_run = 0;

  function automatic int predict(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= int'(N); k++) begin
      if (r[(from + k) % int'(N)]) return (from + k) % int'(N);
    end
    return -1;
  endfunction

  // Grant monitor and expected-response generator.
  always @(negedge clk) begin
    if (clr) begin
      last       = N - 1;
      pred_valid = 1'b0;
      idle_run   = 0;
      exp_q.delete();
    end else begin
      if (pred_valid) begin
        exp_t e;
        bit   go;
        go = (px != '0) && (py != '0);
        check("gnt", longint'(bus.gnt), longint'(1) << pred_idx);
        check("busy_at_gnt", bus.busy, 1);
        check("eng_go", bus.eng_go, go);
        if (go) begin
          check("eng_x", bus.eng_x, px);
          check("eng_y", bus.eng_y, py);
        end
        e.idx = pred_idx;
        if (!go) begin
          e.data = gcd_ref(px, py); e.err = 1'b0; e.cyc = cyc + 1;
        end else if (eng_hang || eng_lat > int'(TIMEOUT)) begin
          e.data = '0; e.err = 1'b1; e.cyc = cyc + int'(TIMEOUT) + 1;
        end else begin
          e.data = gcd_ref(px, py); e.err = 1'b0; e.cyc = cyc + eng_lat + 1;
        end
        exp_q.push_back(e);
        grant_log.push_back(pred_idx);
        pred_valid = 1'b0;
      end else begin
        if (bus.gnt != '0) check("gnt_unexpected", bus.gnt, 0);
        if (bus.eng_go) check("eng_go_unexpected", bus.eng_go, 0);
      end
      if (bus.busy) begin
        if (idle_run != 0) check("idle_gap", idle_run, 1);
        idle_run = 0;
      end else if (req != '0) begin
        idle_run++;
        pred_idx   = predict(req, last);
        px         = req_x[pred_idx*W +: W];
        py         = req_y[pred_idx*W +: W];
        last       = pred_idx;
        pred_valid = 1'b1;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!clr && bus.rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", bus.rsp_valid, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_valid", longint'(bus.rsp_valid), longint'(1) << e.idx);
        check("rsp_data", bus.rsp_data, e.data);
        check("rsp_err", bus.rsp_err, e.err);
        check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Engine model: done pulse eng_lat cycles after eng_go.
  initial begin
    eng_pulse = 1'b0;
    eng_val   = '0;
    rnd_lat   = 3;
    forever begin
      @(negedge clk);
      if (bus.eng_go && !eng_hang && !clr) begin
        logic [W-1:0] a, b;
        int           l;
        a = bus.eng_x;
        b = bus.eng_y;
        l = eng_lat;
        repeat (l) @(posedge clk);
        #1;
        eng_pulse = 1'b1;
        eng_val   = gcd_ref(a, b);
        @(posedge clk);
        #1;
        eng_pulse = 1'b0;
        eng_val   = '0;
        rnd_lat   = $urandom_range(1, 20);
      end
    end
  end

  task automatic request(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
    int t;
    @(posedge clk);
    #1;
    req[i]             = 1'b1;
    req_x[i*W +: W]    = x;
    req_y[i*W +: W]    = y;
    t = 0;
    @(negedge clk);
    while (!bus.gnt[i] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("gnt_wait", bus.gnt[i], 1);
    @(posedge clk);
    #1;
    req[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.busy || req != '0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("idle_wait", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, bus.gnt, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_data"}, bus.rsp_data, 0);
    check({tag, "_rsp_err"}, bus.rsp_err, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_eng_go"}, bus.eng_go, 0);
    check({tag, "_eng_x"}, bus.eng_x, 0);
    check({tag, "_eng_y"}, bus.eng_y, 0);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    check_all_zero("clr");
    @(negedge clk);
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic rand_jobs(input int i);
    logic [W-1:0] x, y;
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      x = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(0, 15));
      y = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(0, 15));
      request(i, x, y);
    end
  endtask

  int base;
  int order_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    late_pulse = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    clr = 1'b0;

    // Single engine job.
    request(2, 4'd12, 4'd8);
    wait_idle();

    // All requesters from reset; requester 0 comes back for a second job.
    pulse_clr();
    base = grant_log.size();
    fork
      begin request(0, 4'd6, 4'd9); request(0, 4'd14, 4'd7); end
      request(1, 4'd15, 4'd5);
      request(2, 4'd8, 4'd12);
      request(3, 4'd13, 4'd3);
    join
    wait_idle();
    check("order_count", grant_log.size() - base, 5);
    for (int k = 0; k < 5; k++) begin
      if (base + k < grant_log.size()) check("grant_order", grant_log[base + k], order_exp[k]);
    end

    // Zero operands are resolved locally.
    request(1, 4'd0, 4'd9);
    request(3, 4'd0, 4'd0);
    request(0, 4'd11, 4'd0);
    wait_idle();

    // Watchdog abort, then a stray done, then a normal job.
    eng_hang = 1'b1;
    request(0, 4'd5, 4'd7);
    wait_idle();
    eng_hang = 1'b0;
    @(posedge clk);
    #1;
    late_pulse = 1'b1;
    @(posedge clk);
    #1;
    late_pulse = 1'b0;
    repeat (5) @(negedge clk);
    request(2, 4'd15, 4'd10);
    wait_idle();

    // Done on the last watchdog cycle wins; one cycle later it is too late.
    lat_cfg = TIMEOUT;
    request(3, 4'd9, 4'd6);
    wait_idle();
    lat_cfg = TIMEOUT + 1;
    request(1, 4'd9, 4'd6);
    wait_idle();
    lat_cfg = 5;

    // Reset mid-wait drops the job; requester 0 wins afterwards.
    eng_hang = 1'b1;
    request(2, 4'd5, 4'd7);
    repeat (10) @(posedge clk);
    pulse_clr();
    eng_hang = 1'b0;
    repeat (TIMEOUT + 5) @(negedge clk);
    base = grant_log.size();
    fork
      request(1, 4'd4, 4'd6);
      request(3, 4'd10, 4'd4);
      request(0, 4'd3, 4'd9);
    join
    wait_idle();
    if (grant_log.size() > base) check("first_after_clr", grant_log[base], 0);
    else check("first_after_clr_count", grant_log.size() - base, 3);

    // Randomised traffic with random engine latency.
    eng_rand = 1'b1;
    fork
      rand_jobs(0);
      rand_jobs(1);
      rand_jobs(2);
      rand_jobs(3);
    join
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
